// File: rtl/td_pkg.sv
// Shared types and helpers for the TD-error bank.
package td_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SUM,
        WR
    } td_state_e;

    // Working width for sat_clip; callers sign-extend into it and truncate the result.
    localparam int unsigned CLIP_W = 64;

    // Clip a sign-extended value to the signed range of `width` bits.
    function automatic logic signed [CLIP_W-1:0] sat_clip(
        input  logic signed [CLIP_W-1:0] val,
        input  int unsigned              width,
        output logic                     clipped
    );
        logic signed [CLIP_W-1:0] hi;
        logic signed [CLIP_W-1:0] lo;
        hi       = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo       = -(64'sd1 <<< (width - 1));
        clipped  = 1'b0;
        sat_clip = val;
        if (val > hi) begin
            sat_clip = hi;
            clipped  = 1'b1;
        end else if (val < lo) begin
            sat_clip = lo;
            clipped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/td_gamma_mul.sv
// Serial MSB-first shift-add multiply of a signed operand by GAMMA/2^GAMMA_W.
// done is high in the cycle whose closing edge applies the final step, so the
// product is valid from that edge until the next load.
module td_gamma_mul #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned GAMMA_W = 4,
    parameter int unsigned GAMMA   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] operand,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned        ACC_W      = DATA_W + GAMMA_W + 1;
    localparam int unsigned        CNT_W      = $clog2(GAMMA_W + 1);
    localparam logic [GAMMA_W-1:0] GAMMA_BITS = GAMMA_W'(GAMMA);

    logic signed [ACC_W-1:0]   r_p;
    logic        [DATA_W-1:0]  r_opnd;
    logic        [GAMMA_W-1:0] r_gbits;
    logic        [CNT_W-1:0]   r_cnt;
    logic signed [ACC_W-1:0]   w_addend;

    // Sign-extended operand when the current gamma bit is set.
    always_comb begin
        w_addend = '0;
        if (r_gbits[GAMMA_W-1]) begin
            w_addend = {{(ACC_W - DATA_W){r_opnd[DATA_W-1]}}, r_opnd};
        end
    end

    // Accumulate one gamma bit per cycle, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_opnd  <= '0;
            r_gbits <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_p     <= '0;
            r_opnd  <= operand;
            r_gbits <= GAMMA_BITS;
            r_cnt   <= CNT_W'(GAMMA_W);
        end else if (r_cnt != '0) begin
            r_p     <= (r_p <<< 1) + w_addend;
            r_gbits <= r_gbits << 1;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign done = (r_cnt == CNT_W'(1));

    // gamma < 1 keeps the scaled product inside DATA_W, so this slice equals
    // the arithmetic right shift by GAMMA_W (floor).
    assign product = r_p[GAMMA_W +: DATA_W];

endmodule

// File: rtl/td_error_bank.sv
// TD-error generator: delta = reward + gamma*max_qt1 - qt, saturated and
// written into a per-action delta bank.
module td_error_bank
    import td_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned NUM_ACT = 4,
    parameter int unsigned GAMMA_W = 4,
    parameter int unsigned GAMMA   = 14,
    parameter int unsigned AW      = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             act,
    input  logic                      terminal,
    input  logic [DATA_W-1:0]         reward,
    input  logic [DATA_W-1:0]         max_qt1,
    input  logic [DATA_W-1:0]         qt,
    input  logic                      clear_err,
    output logic                      busy,
    output logic                      valid,
    output logic                      sat,
    output logic                      bad_act,
    output logic [DATA_W-1:0]         delta_out,
    output logic [NUM_ACT*DATA_W-1:0] delta_vec
);

    localparam int unsigned SW = DATA_W + 2;

    // FRAC_W only places the binary point; the datapath is scale-free. A format
    // with no integer bits is left visible as a named block in the hierarchy.
    if (FRAC_W >= DATA_W) begin : g_frac_w_exceeds_data_w
    end

    td_state_e          r_state;
    logic [DATA_W-1:0]  r_bank [NUM_ACT];
    logic [AW-1:0]      r_act;
    logic               r_term;
    logic [DATA_W-1:0]  r_reward;
    logic [DATA_W-1:0]  r_qt;
    logic signed [SW-1:0] r_sum;
    logic               r_busy;
    logic               r_valid;
    logic               r_sat;
    logic               r_bad_act;
    logic [DATA_W-1:0]  r_delta_out;

    logic               w_act_ok;
    logic               w_mul_load;
    logic               w_mul_done;
    logic [DATA_W-1:0]  w_prod;
    logic signed [SW-1:0] w_sum;
    logic [DATA_W-1:0]  w_result;
    logic               w_clip_sat;

    assign w_act_ok   = 32'(act) < NUM_ACT;
    assign w_mul_load = (r_state == IDLE) && start && w_act_ok && !terminal;

    td_gamma_mul #(
        .DATA_W (DATA_W),
        .GAMMA_W(GAMMA_W),
        .GAMMA  (GAMMA)
    ) u_gamma_mul (
        .clk    (clk),
        .rst    (rst),
        .load   (w_mul_load),
        .operand(max_qt1),
        .done   (w_mul_done),
        .product(w_prod)
    );

    // reward - qt, plus the gamma term unless the episode ended.
    always_comb begin
        w_sum = {{2{r_reward[DATA_W-1]}}, r_reward} - {{2{r_qt[DATA_W-1]}}, r_qt};
        if (!r_term) begin
            w_sum = w_sum + {{2{w_prod[DATA_W-1]}}, w_prod};
        end
    end

    // Saturate the registered sum to DATA_W.
    always_comb begin
        w_clip_sat = 1'b0;
        w_result   = DATA_W'(sat_clip({{(CLIP_W - SW){r_sum[SW-1]}}, r_sum}, DATA_W, w_clip_sat));
    end

    // Control FSM, operand latches, status outputs and the delta bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_act       <= '0;
            r_term      <= 1'b0;
            r_reward    <= '0;
            r_qt        <= '0;
            r_sum       <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_sat       <= 1'b0;
            r_bad_act   <= 1'b0;
            r_delta_out <= '0;
            for (int unsigned k = 0; k < NUM_ACT; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_valid   <= 1'b0;
            r_bad_act <= 1'b0;
            // Clear first so a coincident write below still lands in its lane.
            if (clear_err) begin
                r_delta_out <= '0;
                for (int unsigned k = 0; k < NUM_ACT; k++) begin
                    r_bank[k] <= '0;
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (!w_act_ok) begin
                            r_bad_act <= 1'b1;
                        end else begin
                            r_act    <= act;
                            r_term   <= terminal;
                            r_reward <= reward;
                            r_qt     <= qt;
                            r_busy   <= 1'b1;
                            r_state  <= terminal ? SUM : MUL;
                        end
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state <= SUM;
                    end
                end
                SUM: begin
                    r_sum   <= w_sum;
                    r_state <= WR;
                end
                WR: begin
                    for (int unsigned k = 0; k < NUM_ACT; k++) begin
                        if (r_act == AW'(k)) begin
                            r_bank[k] <= w_result;
                        end
                    end
                    r_delta_out <= w_result;
                    r_sat       <= w_clip_sat;
                    r_valid     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Flatten the bank onto the lane vector.
    always_comb begin
        delta_vec = '0;
        for (int unsigned k = 0; k < NUM_ACT; k++) begin
            delta_vec[k*DATA_W +: DATA_W] = r_bank[k];
        end
    end

    assign busy      = r_busy;
    assign valid     = r_valid;
    assign sat       = r_sat;
    assign bad_act   = r_bad_act;
    assign delta_out = r_delta_out;

endmodule

// File: tb/tb_td_error_bank.sv
// Self-checking bench for td_error_bank against an arithmetic reference model.
module tb_td_error_bank;

    localparam int DW   = 16;
    localparam int GNUM = 14;
    localparam int GW   = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           start3;
    logic [1:0]     act;
    logic           terminal;
    logic [DW-1:0]  reward;
    logic [DW-1:0]  max_qt1;
    logic [DW-1:0]  qt;
    logic           clear_err;

    logic           busy, valid, sat, bad_act;
    logic [DW-1:0]  delta_out;
    logic [4*DW-1:0] delta_vec;
    logic           busy3, valid3, sat3, bad3;
    logic [DW-1:0]  dout3;
    logic [3*DW-1:0] dvec3;

    int errors = 0;
    int checks = 0;

    // Reference state: expected lane contents, last delta and sat flag.
    int m_bank[4];
    int m_out;
    bit m_sat;

    always #5 clk = ~clk;

    td_error_bank #(
        .DATA_W(16), .FRAC_W(10), .NUM_ACT(4), .GAMMA_W(4), .GAMMA(14)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .act(act), .terminal(terminal),
        .reward(reward), .max_qt1(max_qt1), .qt(qt), .clear_err(clear_err),
        .busy(busy), .valid(valid), .sat(sat), .bad_act(bad_act),
        .delta_out(delta_out), .delta_vec(delta_vec)
    );

    // Three-lane instance so that an out-of-range action index is reachable.
    td_error_bank #(
        .DATA_W(16), .FRAC_W(10), .NUM_ACT(3), .GAMMA_W(4), .GAMMA(14)
    ) dut3 (
        .clk(clk), .rst(rst), .start(start3), .act(act), .terminal(terminal),
        .reward(reward), .max_qt1(max_qt1), .qt(qt), .clear_err(1'b0),
        .busy(busy3), .valid(valid3), .sat(sat3), .bad_act(bad3),
        .delta_out(dout3), .delta_vec(dvec3)
    );

    // delta = reward + floor(maxq*14/16) - qt, clipped to 16-bit signed.
    function automatic int model_delta(input logic [DW-1:0] rw, input logic [DW-1:0] mq,
                                       input logic [DW-1:0] q, input logic term, output bit s);
        int g;
        int v;
        g = 0;
        if (!term) begin
            g = int'($signed(mq)) * GNUM;
            if (g >= 0) g = g / (1 << GW);
            else        g = -((-g + (1 << GW) - 1) / (1 << GW));
        end
        v = g + int'($signed(rw)) - int'($signed(q));
        s = 1'b0;
        if (v > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1'b1;
        end
        return v;
    endfunction

    // Issue one request on dut, scramble inputs after acceptance, wait for valid.
    task automatic run_req(input logic [1:0] a, input logic t, input logic [DW-1:0] rw,
                           input logic [DW-1:0] mq, input logic [DW-1:0] q, output int lat);
        act = a; terminal = t; reward = rw; max_qt1 = mq; qt = q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        act = 2'($urandom); terminal = 1'($urandom);
        reward = 16'($urandom); max_qt1 = 16'($urandom); qt = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
        checks++; if (bad_act !== 1'b0) begin errors++; $display("FAIL reset_bad_act: got %b want 0", bad_act); end
        checks++; if (delta_out !== '0) begin errors++; $display("FAIL reset_delta_out: got %h want 0", delta_out); end
        checks++; if (delta_vec !== '0) begin errors++; $display("FAIL reset_delta_vec: got %h want 0", delta_vec); end
        checks++; if (dvec3 !== '0) begin errors++; $display("FAIL reset_dvec3: got %h want 0", dvec3); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) m_bank[k] = 0;
        m_out = 0;
        m_sat = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    a;
        logic          t;
        logic [DW-1:0] rw;
        logic [DW-1:0] mq;
        logic [DW-1:0] q;
        logic [DW-1:0] want;
        logic          s;
        int            lat;
    } vec_t;

    task automatic test_directed();
        vec_t tv[5];
        logic [DW-1:0] fin[4];
        logic [DW-1:0] lv;
        int lat;
        tv[0] = '{2'd0, 1'b0, 16'h1400, 16'h1400, 16'h0400, 16'h2180, 1'b0, 6};
        tv[1] = '{2'd1, 1'b0, 16'h2800, 16'h0C00, 16'h0A00, 16'h2880, 1'b0, 6};
        tv[2] = '{2'd2, 1'b0, 16'h7C00, 16'h7C00, 16'hFC00, 16'h7FFF, 1'b1, 6};
        tv[3] = '{2'd2, 1'b0, 16'h8400, 16'h8400, 16'h0400, 16'h8000, 1'b1, 6};
        tv[4] = '{2'd3, 1'b1, 16'h1400, 16'h7FFF, 16'h0400, 16'h1000, 1'b0, 2};
        fin[0] = 16'h2180; fin[1] = 16'h2880; fin[2] = 16'h8000; fin[3] = 16'h1000;
        for (int i = 0; i < 5; i++) begin
            run_req(tv[i].a, tv[i].t, tv[i].rw, tv[i].mq, tv[i].q, lat);
            lv = delta_vec[int'(tv[i].a)*DW +: DW];
            checks++; if (lat !== tv[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tv[i].lat); end
            checks++; if (lv !== tv[i].want) begin errors++; $display("FAIL dir%0d_lane: got %h want %h", i, lv, tv[i].want); end
            checks++; if (delta_out !== tv[i].want) begin errors++; $display("FAIL dir%0d_delta_out: got %h want %h", i, delta_out, tv[i].want); end
            checks++; if (sat !== tv[i].s) begin errors++; $display("FAIL dir%0d_sat: got %b want %b", i, sat, tv[i].s); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_in_valid: got %b want 0", i, busy); end
            m_bank[tv[i].a] = int'($signed(tv[i].want));
            m_out = m_bank[tv[i].a];
            m_sat = tv[i].s;
        end
        for (int k = 0; k < 4; k++) begin
            lv = delta_vec[k*DW +: DW];
            checks++; if (lv !== fin[k]) begin errors++; $display("FAIL dir_final_lane%0d: got %h want %h", k, lv, fin[k]); end
        end
    endtask

    // Random requests issued back to back: each start lands in the previous valid cycle.
    task automatic test_random_back_to_back();
        logic [1:0] a;
        logic t;
        logic [DW-1:0] rw, mq, q, lv;
        bit s;
        int want, lat, wlat;
        for (int i = 0; i < 40; i++) begin
            a  = 2'($urandom_range(0, 3));
            t  = ($urandom_range(0, 7) == 0);
            rw = 16'($urandom); mq = 16'($urandom); q = 16'($urandom);
            want = model_delta(rw, mq, q, t, s);
            wlat = t ? 2 : 6;
            run_req(a, t, rw, mq, q, lat);
            m_bank[a] = want; m_out = want; m_sat = s;
            checks++; if (lat !== wlat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, wlat); end
            checks++; if (delta_out !== 16'(want)) begin errors++; $display("FAIL rnd%0d_delta_out: got %h want %h", i, delta_out, 16'(want)); end
            checks++; if (sat !== s) begin errors++; $display("FAIL rnd%0d_sat: got %b want %b", i, sat, s); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy_in_valid: got %b want 0", i, busy); end
            for (int k = 0; k < 4; k++) begin
                lv = delta_vec[k*DW +: DW];
                checks++; if (lv !== 16'(m_bank[k])) begin errors++; $display("FAIL rnd%0d_lane%0d: got %h want %h", i, k, lv, 16'(m_bank[k])); end
            end
        end
    endtask

    // start held high for the whole operation with changing inputs: one result only.
    task automatic test_start_held();
        logic [DW-1:0] lv;
        bit s;
        int want, lat, nv;
        act = 2'd1; terminal = 1'b0; reward = 16'h0C00; max_qt1 = 16'hF000; qt = 16'h0200;
        want = model_delta(reward, max_qt1, qt, 1'b0, s);
        start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        nv  = 0;
        for (int n = 1; n <= 30; n++) begin
            if (lat < 0) begin
                act = 2'($urandom); terminal = 1'($urandom);
                reward = 16'($urandom); max_qt1 = 16'($urandom); qt = 16'($urandom);
            end
            @(posedge clk); #1;
            if (valid) begin
                nv++;
                if (lat < 0) lat = n;
                start = 1'b0;
            end
        end
        start = 1'b0;
        m_bank[1] = want; m_out = want; m_sat = s;
        lv = delta_vec[1*DW +: DW];
        checks++; if (nv !== 1) begin errors++; $display("FAIL held_valid_count: got %0d want 1", nv); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL held_latency: got %0d want 6", lat); end
        checks++; if (lv !== 16'(want)) begin errors++; $display("FAIL held_lane1: got %h want %h", lv, 16'(want)); end
        checks++; if (sat !== s) begin errors++; $display("FAIL held_sat: got %b want %b", sat, s); end
    endtask

    // A lone clear_err mid-operation empties the bank without disturbing the FSM.
    task automatic test_clear_mid();
        logic [DW-1:0] lv;
        bit s;
        int want, lat;
        act = 2'd0; terminal = 1'b0; reward = 16'h0400; max_qt1 = 16'h0800; qt = 16'h0100;
        want = model_delta(reward, max_qt1, qt, 1'b0, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            clear_err = (n == 2);
            @(posedge clk); #1;
            clear_err = 1'b0;
            if (n == 2) begin
                checks++; if (delta_vec !== '0) begin errors++; $display("FAIL clrmid_bank: got %h want 0", delta_vec); end
                checks++; if (delta_out !== '0) begin errors++; $display("FAIL clrmid_delta_out: got %h want 0", delta_out); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clrmid_busy: got %b want 1", busy); end
            end
            if (valid) begin
                lat = n;
                break;
            end
        end
        for (int k = 0; k < 4; k++) m_bank[k] = 0;
        m_bank[0] = want; m_out = want; m_sat = s;
        lv = delta_vec[0 +: DW];
        checks++; if (lat !== 6) begin errors++; $display("FAIL clrmid_latency: got %0d want 6", lat); end
        checks++; if (lv !== 16'(want)) begin errors++; $display("FAIL clrmid_lane0: got %h want %h", lv, 16'(want)); end
    endtask

    // clear_err on the write edge: written lane keeps the new result, others zero.
    task automatic test_clear_coincident();
        logic [DW-1:0] lv;
        logic [DW-1:0] want;
        int lat;
        for (int a = 0; a < 4; a++) begin
            if (a != 1) begin
                run_req(2'(a), 1'b1, 16'h0400, 16'h0000, 16'h0000, lat);
                m_bank[a] = 16'h0400;
            end
        end
        act = 2'd1; terminal = 1'b0; reward = 16'h2800; max_qt1 = 16'h0C00; qt = 16'h0A00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            clear_err = (n == 6);
            @(posedge clk); #1;
            clear_err = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== 6) begin errors++; $display("FAIL clrwr_latency: got %0d want 6", lat); end
        for (int k = 0; k < 4; k++) begin
            lv   = delta_vec[k*DW +: DW];
            want = (k == 1) ? 16'h2880 : 16'h0000;
            checks++; if (lv !== want) begin errors++; $display("FAIL clrwr_lane%0d: got %h want %h", k, lv, want); end
            m_bank[k] = int'($signed(want));
        end
        checks++; if (delta_out !== 16'h2880) begin errors++; $display("FAIL clrwr_delta_out: got %h want 2880", delta_out); end
        m_out = 16'h2880;
        m_sat = 1'b0;
    endtask

    // Reset three edges after acceptance aborts the operation and clears the bank.
    task automatic test_rst_midop();
        int nv;
        act = 2'd2; terminal = 1'b0; reward = 16'h1000; max_qt1 = 16'h1000; qt = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", busy); end
        checks++; if (delta_vec !== '0) begin errors++; $display("FAIL rst_bank: got %h want 0", delta_vec); end
        checks++; if (delta_out !== '0) begin errors++; $display("FAIL rst_delta_out: got %h want 0", delta_out); end
        nv = 0;
        for (int n = 0; n < 10; n++) begin
            if (valid) nv++;
            @(posedge clk); #1;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL rst_no_valid: got %0d valids want 0", nv); end
        for (int k = 0; k < 4; k++) m_bank[k] = 0;
        m_out = 0;
        m_sat = 1'b0;
    endtask

    // On the three-lane instance act=3 is rejected; act=2 is the highest legal lane.
    task automatic test_bad_act();
        logic [DW-1:0] lv;
        bit s;
        int want, lat, nv;
        act = 2'd3; terminal = 1'b0; reward = 16'h0400; max_qt1 = 16'h0400; qt = 16'h0000;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        checks++; if (bad3 !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b want 1", bad3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", busy3); end
        @(posedge clk); #1;
        checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL bad_pulse_width: got %b want 0", bad3); end
        nv = 0;
        for (int n = 0; n < 10; n++) begin
            if (valid3) nv++;
            @(posedge clk); #1;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL bad_no_valid: got %0d valids want 0", nv); end
        checks++; if (dvec3 !== '0) begin errors++; $display("FAIL bad_bank: got %h want 0", dvec3); end
        act = 2'd2; reward = 16'h1400; max_qt1 = 16'h1400; qt = 16'h0400;
        want = model_delta(reward, max_qt1, qt, 1'b0, s);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (valid3) begin
                lat = n;
                break;
            end
        end
        lv = dvec3[2*DW +: DW];
        checks++; if (lat !== 6) begin errors++; $display("FAIL top_lane_latency: got %0d want 6", lat); end
        checks++; if (lv !== 16'(want)) begin errors++; $display("FAIL top_lane_value: got %h want %h", lv, 16'(want)); end
        checks++; if (dout3 !== 16'(want)) begin errors++; $display("FAIL top_lane_delta_out: got %h want %h", dout3, 16'(want)); end
        checks++; if (sat3 !== s) begin errors++; $display("FAIL top_lane_sat: got %b want %b", sat3, s); end
        checks++; if (dvec3[0 +: 2*DW] !== '0) begin errors++; $display("FAIL top_lane_others: got %h want 0", dvec3[0 +: 2*DW]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; act = '0; terminal = 1'b0;
        reward = '0; max_qt1 = '0; qt = '0; clear_err = 1'b0;
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_start_held();
        test_clear_mid();
        test_clear_coincident();
        test_rst_midop();
        test_bad_act();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
